// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply-divide unit: fixed-latency multiply/accumulate and
// 32-iteration restoring divide, committing results to the HI/LO registers.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } op_e;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'd32;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [5:0]  cnt_q;
  logic [31:0] a_q, b_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic        neg_quo_q, neg_rem_q, dvs_zero_q;
  logic        done_q;
  logic [31:0] hi_q, lo_q;

  // Operands decoded at the request port for divide set-up
  logic        req_signed;
  logic [31:0] req_a_abs, req_b_abs;

  // Multiply datapath
  logic [63:0] a_ext, b_ext, prod, acc, mul_res;

  // Divide datapath
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    req_signed = ~req_op[0];
    req_a_abs  = (req_signed && req_a[31]) ? (~req_a + 32'd1) : req_a;
    req_b_abs  = (req_signed && req_b[31]) ? (~req_b + 32'd1) : req_b;
  end

  // Odd opcodes are the unsigned variants; sign- vs zero-extension to 64 bits
  // lets one truncated 64x64 product serve both.
  always_comb begin
    a_ext = op_q[0] ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
    b_ext = op_q[0] ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  // Remainder stays below the divisor, so bit 32 of the difference is set
  // exactly when the trial subtraction must be undone.
  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dvs_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            case (req_op)
              OP_MTHI: hi_q <= req_a;
              OP_MTLO: lo_q <= req_a;
              OP_DIV, OP_DIVU: begin
                state_q    <= S_DIV;
                op_q       <= req_op;
                cnt_q      <= '0;
                quo_q      <= req_a_abs;
                rem_q      <= '0;
                dvs_q      <= req_b_abs;
                neg_quo_q  <= req_signed && (req_a[31] ^ req_b[31]);
                neg_rem_q  <= req_signed && req_a[31];
                dvs_zero_q <= (req_b == '0);
              end
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                state_q <= S_MUL;
                op_q    <= req_op;
                cnt_q   <= '0;
                a_q     <= req_a;
                b_q     <= req_b;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (cnt_q == MUL_LAST) begin
            hi_q    <= mul_res[63:32];
            lo_q    <= mul_res[31:0];
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (cnt_q == DIV_LAST) begin
            if (!dvs_zero_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            if (diff[32]) begin
              rem_q <= rem_sh[31:0];
              quo_q <= {quo_q[30:0], 1'b0};
            end else begin
              rem_q <= diff[31:0];
              quo_q <= {quo_q[30:0], 1'b1};
            end
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl (MUL_LAT = 3).
module tb_hilo_muldiv_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] exp64;

  hilo_muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  // Counts busy cycles from the first busy cycle; leaves time in the done cycle.
  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; flush = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    // A request presented while reset is sampled high is ignored
    req_valid = 1'b1; req_op = 4'd8; req_a = 32'h9;
    tick();
    reset = 1'b0; req_valid = 1'b0;
    chk("rst_req_ignored", {hi, lo}, 64'd0);

    issue(4'd0, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy", 64'(busy), 64'd1);
    wait_done("mult", LAT);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    tick();
    chk("mult_done_pulse", 64'(done), 64'd0);

    issue(4'd2, 32'hFFFFFFF9, 32'd2);
    wait_done("div", 33);
    chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_done("divu", 33);
    chk("divu_hilo", {hi, lo}, 64'h00000001_7FFFFFFC);
    issue(4'd2, 32'd7, 32'hFFFFFFFE);
    wait_done("div_negb", 33);
    chk("div_negb_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

    issue(4'd8, 32'd5, 32'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    chk("mthi_hi", 64'(hi), 64'd5);
    issue(4'd9, 32'd7, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'd7);
    issue(4'd5, 32'hFFFFFFFF, 32'd2);
    wait_done("maddu", LAT);
    exp64 = {32'd5, 32'd7} + 64'h0000_0001_FFFF_FFFE;
    chk("maddu_hilo", {hi, lo}, exp64);
    // Signed product 3 * -1 = -3 subtracted from the accumulator
    issue(4'd6, 32'd3, 32'hFFFFFFFF);
    wait_done("msub", LAT);
    chk("msub_hilo", {hi, lo}, exp64 + 64'd3);

    issue(4'd8, 32'h11, 32'd0);
    issue(4'd9, 32'h22, 32'd0);
    issue(4'd3, 32'd5, 32'd0);
    wait_done("divz", 33);
    chk("divz_hilo", {hi, lo}, 64'h00000011_00000022);

    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 33);
    chk("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

    issue(4'd2, 32'd100, 32'd7);
    repeat (9) tick();
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'h00000000_80000000);
    tick();
    chk("flush_done2", 64'(done), 64'd0);

    flush = 1'b1;
    issue(4'd8, 32'hDEAD, 32'd0);
    chk("flushprio_hi", 64'(hi), 64'd0);
    issue(4'd0, 32'd2, 32'd2);
    flush = 1'b0;
    chk("flushprio_busy", 64'(busy), 64'd0);

    issue(4'd12, 32'd1, 32'd1);
    chk("rsvd_busy", 64'(busy), 64'd0);
    chk("rsvd_done", 64'(done), 64'd0);
    chk("rsvd_hilo", {hi, lo}, 64'h00000000_80000000);

    issue(4'd0, 32'd6, 32'd7);
    wait_done("b2b_first", LAT);
    chk("b2b_first_hilo", {hi, lo}, 64'd42);
    issue(4'd0, 32'hFFFFFFFB, 32'hFFFFFFFC);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done("b2b_second", LAT);
    chk("b2b_second_hilo", {hi, lo}, 64'd20);

    issue(4'd0, 32'd9, 32'd9);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("amid_busy", 64'(busy), 64'd0);
    chk("amid_done", 64'(done), 64'd0);
    chk("amid_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("amid_after", {64'(busy), 64'(done)} == 128'd0 ? 64'd0 : 64'd1, 64'd0);

    issue(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu", LAT);
    chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
